// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops bytes from a byte FIFO and sends them as 8N1 frames.
// Define UART_TX_PARITY_EN to add an even-parity bit between D7 and the stop bit (8E1).
module fifo_uart_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t          state, state_next;
    logic [CW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shift, shift_next;
    logic            tx_next;
    logic            done_next;
    logic            bit_end;

`ifdef UART_TX_PARITY_EN
    logic            parity_bit, parity_next;
`endif

    // The pop is gated by reset so no byte is consumed while the block is held in reset.
    assign fifo_pop = (state == IDLE) && !fifo_empty && !rst;
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
            tx_done  <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as popped, since the shift register is consumed by DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else begin
            parity_bit <= parity_next;
        end
    end
`endif

    // tx is registered from the next state, so the start bit appears right after the pop edge.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        bit_end    = (baud_cnt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif

        if (state != IDLE) begin
            baud_next = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (fifo_pop) begin
                    shift_next = fifo_rdata;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_rdata;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a frame-timeline model of the serial line checked every cycle,
// plus directed frames whose timing and decoded bytes are pinned to hand-computed values.
module tb_fifo_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * DIV;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] fifo_mem [0:15];
    int         rd_ptr = 0;
    int         wr_ptr = 0;

    int errors = 0;
    int checks = 0;

    int   cycle = 0;
    logic tx_log [0:4095];
    int   pop_cyc [0:15];
    int   done_cyc [0:15];
    int   pop_count = 0;
    int   done_count = 0;

    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits = '1;

    fifo_uart_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = (fifo_pop && !fifo_empty) ? fifo_mem[rd_ptr[3:0]] : 8'hzz;

    always @(posedge clk) begin
        if (fifo_pop && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic waitPops(input int target, input int budget);
        int n = 0;
        while (pop_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("wait_pop", pop_count, target);
    endtask

    task automatic waitDones(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("wait_done", done_count, target);
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    function automatic logic lineBit(input int pc, input int k);
        return tx_log[(pc + 1 + k * DIV + DIV / 2) % 4096];
    endfunction

    function automatic logic [7:0] decodeByte(input int pc);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = lineBit(pc, k + 1);
        return b;
    endfunction

    // Timeline model: a pop starts a FRAME_LEN-cycle frame; the line shows bit (t / DIV).
    always @(negedge clk) begin
        bit act_now;
        bit exp_pop;
        logic exp_tx;
        act_now = m_active && !rst;
        exp_pop = !m_active && !fifo_empty && !rst;
        exp_tx  = act_now ? m_bits[m_t / DIV] : 1'b1;

        checkOutput("model_tx", {31'd0, tx}, {31'd0, exp_tx});
        checkOutput("model_busy", {31'd0, tx_busy}, {31'd0, act_now});
        checkOutput("model_done", {31'd0, tx_done}, {31'd0, m_done && !rst});
        checkOutput("model_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});

        tx_log[cycle % 4096] = tx;
        if (fifo_pop) begin
            if (pop_count < 16) pop_cyc[pop_count] = cycle;
            pop_count++;
        end
        if (tx_done) begin
            if (done_count < 16) done_cyc[done_count] = cycle;
            done_count++;
        end
        cycle++;

        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (exp_pop) begin
            m_active = 1'b1;
            m_t      = 0;
            m_bits   = frameBits(fifo_mem[rd_ptr[3:0]]);
            m_done   = 1'b0;
        end else if (m_active) begin
            if (m_t == FRAME_LEN - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_t++;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pat55 [0:8];
        pat55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        rst = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("reset_done", {31'd0, tx_done}, 32'd0);
        checkOutput("reset_pop", {31'd0, fifo_pop}, 32'd0);
        rst = 1'b0;

        $display("[TB] idle with empty FIFO");
        repeat (500) @(posedge clk);
        #1;
        checkOutput("idle_pops", pop_count, 32'd0);
        checkOutput("idle_tx", {31'd0, tx}, 32'd1);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55);
        waitPops(1, 20);
        waitDones(1, FRAME_LEN + 20);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("single_pop_count", pop_count, 32'd1);
        checkOutput("single_done_count", done_count, 32'd1);
        checkOutput("single_latency", done_cyc[0] - pop_cyc[0], FRAME_LEN + 1);
        for (int k = 0; k < 9; k++) checkOutput("single_bit", {31'd0, lineBit(pop_cyc[0], k)}, pat55[k]);
        checkOutput("single_stop", {31'd0, lineBit(pop_cyc[0], FRAME_BITS - 1)}, 32'd1);

        $display("[TB] three back-to-back frames");
        applyStimulus(8'hA3);
        applyStimulus(8'h0F);
        applyStimulus(8'hFF);
        waitDones(4, 4 * FRAME_LEN);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("b2b_byte0", decodeByte(pop_cyc[1]), 32'hA3);
        checkOutput("b2b_byte1", decodeByte(pop_cyc[2]), 32'h0F);
        checkOutput("b2b_byte2", decodeByte(pop_cyc[3]), 32'hFF);
        checkOutput("b2b_period0", pop_cyc[2] - pop_cyc[1], FRAME_LEN + 1);
        checkOutput("b2b_period1", pop_cyc[3] - pop_cyc[2], FRAME_LEN + 1);
        checkOutput("b2b_pop_on_done", pop_cyc[3], done_cyc[2]);
        checkOutput("b2b_pop_count", pop_count, 32'd4);
        checkOutput("b2b_empty", {31'd0, fifo_empty}, 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h00);
        waitPops(5, 20);
        repeat (36) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", {31'd0, tx}, 32'd1);
        checkOutput("midrst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        checkOutput("midrst_no_done", done_count, 32'd4);
        checkOutput("midrst_no_pop", pop_count, 32'd5);
        checkOutput("midrst_idle_busy", {31'd0, tx_busy}, 32'd0);

        $display("[TB] refill during a frame");
        applyStimulus(8'h3C);
        waitPops(6, 20);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(8'hC3);
        waitDones(6, 3 * FRAME_LEN);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("refill_pop_count", pop_count, 32'd7);
        checkOutput("refill_pop_on_done", pop_cyc[6], done_cyc[4]);
        checkOutput("refill_period", pop_cyc[6] - pop_cyc[5], FRAME_LEN + 1);
        checkOutput("refill_byte0", decodeByte(pop_cyc[5]), 32'h3C);
        checkOutput("refill_byte1", decodeByte(pop_cyc[6]), 32'hC3);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h07);
        waitPops(8, 20);
        waitDones(7, FRAME_LEN + 20);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("parity_a3", {31'd0, lineBit(pop_cyc[1], 9)}, 32'd0);
        checkOutput("parity_07", {31'd0, lineBit(pop_cyc[7], 9)}, 32'd1);
        checkOutput("parity_len", done_cyc[6] - pop_cyc[7], 32'd111);
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
